uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serialises one parallel byte into an asynchronous UART frame: start bit (0), DATA_BITS
//   data bits LSB first, then STOP_BITS stop bits (1). Sits directly upstream of the UART
//   receiver and drives its serial rx_in line; parallel side takes bytes via valid/ready.
//   Line idles high. No parity.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles each serial bit is held on tx_out (>=2)
//   DATA_BITS     8   data bits per frame (5..8); tx_data bits above DATA_BITS-1 ignored
//   STOP_BITS     1   stop bits per frame (1 or 2)
// PORTS
//   clk       in   1  single system clock; all logic on posedge
//   rst       in   1  synchronous, active-high reset
//   tx_data   in   8  byte to send; sampled only on accept
//   tx_valid  in   1  upstream has a byte on tx_data
//   tx_ready  out  1  block can accept a byte this cycle (high only in IDLE)
//   tx_out    out  1  serial line to receiver; idle/stop = 1, start = 0
//   tx_busy   out  1  frame in progress (START, DATA or STOP state)
//   tx_done   out  1  one-cycle pulse: frame fully transmitted
// BEHAVIOUR
//   - All outputs registered. Reset (rst=1 at posedge): state=IDLE, tx_out=1, tx_ready=1,
//     tx_busy=0, tx_done=0, baud counter=0, bit index=0, shift reg=0.
//   - Accept: tx_valid & tx_ready at posedge -> tx_data latched into shift reg; next cycle
//     state=START, tx_out=0, tx_ready=0, tx_busy=1. Latency accept->start edge: 1 cycle.
//   - FSM: IDLE -> START (on accept) -> DATA (after CLKS_PER_BIT cycles) -> STOP (after
//     DATA_BITS*CLKS_PER_BIT cycles) -> IDLE (after STOP_BITS*CLKS_PER_BIT cycles).
//   - Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 and emits bit_tick on the last
//     count; cleared on accept so every frame starts phase-aligned.
//   - DATA: tx_out = shift_reg[0]; on bit_tick shift right by 1, bit index +1; leave DATA
//     when bit index reaches DATA_BITS-1 at bit_tick.
//   - STOP: tx_out=1; stop-bit counter 0..STOP_BITS-1.
//   - Completion: on final STOP bit_tick -> next cycle state=IDLE, tx_busy=0, tx_ready=1,
//     tx_done=1 for exactly that one cycle.
//   - Frame length = (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles of non-idle line.
//   - Back-to-back: with tx_valid held high, next accept occurs in the tx_done cycle; next
//     start bit follows one cycle later (exactly 1 extra idle-high cycle between frames).
//   - tx_valid while busy: ignored (ready low), no data loss upstream since no handshake.
//   - tx_data changes after accept: no effect on frame in flight.
//   - rst mid-frame: frame abandoned, tx_out=1 next cycle, no tx_done pulse.
//   - rst and tx_valid same cycle: rst wins, nothing accepted.
// STRUCTURE
//   - uart_pkg: state enum {IDLE, START, DATA, STOP}, line-level constants
//     (UART_IDLE=1, UART_START=0, UART_STOP=1), default CLKS_PER_BIT; shared with receiver.
//   - Sub-module uart_baud_tick: parameter CLKS_PER_BIT; ports clk, rst, clear, bit_tick;
//     counter width $clog2(CLKS_PER_BIT). Receiver reuses it.
//   - Top: FSM, shift register, bit index and stop counters, output registers.
// TESTING
//   1 Reset: rst=1 3 cycles -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
//   2 Single byte 0xA5, CLKS_PER_BIT=16 -> tx_out 0,1,0,1,0,0,1,0,1,1 each held 16 cycles;
//     tx_done pulses once, 161 cycles after accept; receiver model decodes 0xA5.
//   3 Back-to-back 0x00 then 0xFF, tx_valid held -> exactly 1 idle-high cycle between
//     stop of frame 1 and start of frame 2; two tx_done pulses 161 cycles apart.
//   4 tx_valid pulsed and tx_data toggled during frame of 0x3C -> ignored; line carries
//     0x3C only, tx_ready stays 0 until tx_done.
//   5 rst asserted mid-DATA (bit 4) -> tx_out=1 next cycle, no tx_done; fresh byte 0x81
//     after reset transmits correctly.
//   6 STOP_BITS=2, DATA_BITS=7, byte 0x55 -> 2 stop bits (32 cycles high), frame 160
//     cycles, bit 7 of tx_data never appears on line.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, state encoding and defaults.
// The transmitter and the matching receiver both import this package.
package uart_pkg;

    // Default bit period in system clocks.
    localparam int UART_CLKS_PER_BIT_DEFAULT = 16;

    // Widest frame payload supported on the parallel side.
    localparam int UART_MAX_DATA_BITS = 8;

    // Serial line levels.
    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;

    // Frame state encoding: IDLE, START, DATA, STOP.
    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // Mask that keeps only the low data_bits of a byte.
    function automatic logic [7:0] uart_data_mask(input int data_bits);
        return 8'((1 << data_bits) - 1);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count.
// A clear restarts the period so a new frame begins phase-aligned.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Tick is high for the final clock of every bit period.
    assign bit_tick = (r_count == LAST);

    // Free-running period counter, restarted by reset, clear or wrap.
    // NOTE: clocked state uses <= so every flop samples pre-edge values;
    // a blocking = here would let later statements see the new value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (bit_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends
// start bit, DATA_BITS data bits LSB first, then STOP_BITS stop bits.
// Every output comes straight from a flop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [7:0] DATA_MASK = uart_data_mask(DATA_BITS);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_stop_cnt;
    logic        r_tx_out;
    logic        r_tx_ready;
    logic        r_tx_busy;
    logic        r_tx_done;

    logic        w_accept;
    logic        w_bit_tick;

    // Ready is only ever high in IDLE, so this is the one accept condition.
    assign w_accept = tx_valid && r_tx_ready;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_accept),
        .bit_tick (w_bit_tick)
    );

    // Frame sequencer: state, shift register, counters and output flops.
    // NOTE: the shift register is reset as well, even though every accept
    // overwrites it, so its contents are never unknown after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx_out   <= UART_IDLE;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_START;
                        r_shift    <= tx_data & DATA_MASK;
                        r_bit_idx  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_tx_out   <= UART_START;
                        r_tx_ready <= 1'b0;
                        r_tx_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_bit_tick) begin
                        r_state  <= ST_DATA;
                        r_tx_out <= r_shift[0];
                    end
                end

                ST_DATA: begin
                    if (w_bit_tick) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == LAST_BIT) begin
                            r_state    <= ST_STOP;
                            r_stop_cnt <= 1'b0;
                            r_tx_out   <= UART_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            // The bit that becomes LSB after this shift.
                            r_tx_out  <= r_shift[1];
                        end
                    end
                end

                ST_STOP: begin
                    if (w_bit_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_state    <= ST_IDLE;
                            r_tx_out   <= UART_IDLE;
                            r_tx_ready <= 1'b1;
                            r_tx_busy  <= 1'b0;
                            r_tx_done  <= 1'b1;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_out   <= UART_IDLE;
                    r_tx_ready <= 1'b1;
                    r_tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out   = r_tx_out;
    assign tx_ready = r_tx_ready;
    assign tx_busy  = r_tx_busy;
    assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (8N1 and 7N2, 16 clocks per
// bit), a per-cycle waveform model for each, plus decoded-frame and
// latency checks with literal expectations.
module tb_uart_transmitter;

    localparam int CPB = 16;
    localparam int DB0 = 8;
    localparam int SB0 = 1;
    localparam int DB1 = 7;
    localparam int SB1 = 2;

    logic       clk = 1'b0;
    logic       rst_v      [2];
    logic       tx_valid_v [2];
    logic [7:0] tx_data_v  [2];
    logic       tx_ready_v [2];
    logic       tx_out_v   [2];
    logic       tx_busy_v  [2];
    logic       tx_done_v  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DB = (g == 0) ? DB0 : DB1;
        localparam int SB = (g == 0) ? SB0 : SB1;

        uart_transmitter #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .STOP_BITS    (SB)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_v[g]),
            .tx_data  (tx_data_v[g]),
            .tx_valid (tx_valid_v[g]),
            .tx_ready (tx_ready_v[g]),
            .tx_out   (tx_out_v[g]),
            .tx_busy  (tx_busy_v[g]),
            .tx_done  (tx_done_v[g])
        );

        // Model: the whole line waveform of a frame is queued at accept;
        // one entry is consumed per clock, and emptying the queue marks done.
        bit         line_q [$];
        bit         m_done = 1'b0;
        logic [7:0] m_data;

        always @(posedge clk) begin
            if (rst_v[g]) begin
                line_q.delete();
                m_done = 1'b0;
            end else if (line_q.size() != 0) begin
                void'(line_q.pop_front());
                m_done = (line_q.size() == 0);
            end else begin
                m_done = 1'b0;
                if (tx_valid_v[g]) begin
                    m_data = tx_data_v[g];
                    for (int i = 0; i < CPB; i++) line_q.push_back(1'b0);
                    for (int b = 0; b < DB; b++)
                        for (int i = 0; i < CPB; i++) line_q.push_back(m_data[b]);
                    for (int i = 0; i < SB * CPB; i++) line_q.push_back(1'b1);
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("i%0d tx_out", g),   tx_out_v[g],   (line_q.size() != 0) ? line_q[0] : 1'b1);
            check($sformatf("i%0d tx_busy", g),  tx_busy_v[g],  line_q.size() != 0);
            check($sformatf("i%0d tx_ready", g), tx_ready_v[g], line_q.size() == 0);
            check($sformatf("i%0d tx_done", g),  tx_done_v[g],  m_done);
        end
    end

    task automatic wait_done(input int g, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_done_v[g] === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout i%0d: no tx_done within %0d cycles", g, budget);
        end
    endtask

    // Sends one byte, decodes the line at mid-bit like a receiver, then
    // checks payload, framing and valid-to-done latency.
    task automatic send_frame(input int g, input logic [7:0] data, input int db, input int sb);
        int         t0;
        int         t_done;
        int         nbits;
        int         stop_ones;
        logic       start_bit;
        logic       v;
        logic [7:0] dec;
        logic [7:0] mask;
        dec       = '0;
        stop_ones = 0;
        start_bit = 1'b1;
        nbits     = 1 + db + sb;
        mask      = 8'((1 << db) - 1);
        @(posedge clk); #1;
        tx_data_v[g]  = data;
        tx_valid_v[g] = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        tx_valid_v[g] = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            repeat ((b == 0) ? 9 : CPB) @(negedge clk);
            v = tx_out_v[g];
            if (b == 0) start_bit = v;
            else if (b <= db) dec[b-1] = v;
            else if (v === 1'b1) stop_ones++;
        end
        check($sformatf("i%0d start bit of %0h", g, data), start_bit, 1'b0);
        check($sformatf("i%0d decoded byte of %0h", g, data), dec, data & mask);
        check($sformatf("i%0d stop bits of %0h", g, data), stop_ones, sb);
        wait_done(g, 4 * CPB, t_done);
        if (t_done >= 0)
            check($sformatf("i%0d valid-to-done cycles", g), t_done - t0, nbits * CPB + 1);
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        int done_cnt;
        logic [7:0] rnd;

        for (int g = 0; g < 2; g++) begin
            rst_v[g]      = 1'b1;
            tx_valid_v[g] = 1'b0;
            tx_data_v[g]  = 8'h00;
        end

        // Reset held three cycles; the per-cycle model checks every cycle.
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_out", tx_out_v[0], 1'b1);
        check("reset tx_ready", tx_ready_v[0], 1'b1);
        check("reset tx_busy", tx_busy_v[0], 1'b0);
        check("reset tx_done", tx_done_v[1], 1'b0);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;

        // Reset and valid together: nothing is accepted.
        @(posedge clk); #1;
        rst_v[0] = 1'b1; tx_valid_v[0] = 1'b1; tx_data_v[0] = 8'hAA;
        @(posedge clk); #1;
        rst_v[0] = 1'b0; tx_valid_v[0] = 1'b0;
        check("rst+valid busy", tx_busy_v[0], 1'b0);
        check("rst+valid tx_out", tx_out_v[0], 1'b1);

        // Single byte 0xA5.
        send_frame(0, 8'hA5, DB0, SB0);

        // Back-to-back 0x00 then 0xFF with valid held high.
        @(posedge clk); #1;
        tx_data_v[0] = 8'h00; tx_valid_v[0] = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        tx_data_v[0] = 8'hFF;
        wait_done(0, 12 * CPB, t1);
        check("b2b done-cycle line high", tx_out_v[0], 1'b1);
        check("b2b done-cycle ready", tx_ready_v[0], 1'b1);
        @(negedge clk);
        check("b2b second start bit", tx_out_v[0], 1'b0);
        tx_valid_v[0] = 1'b0;
        wait_done(0, 12 * CPB, t2);
        check("b2b first latency", t1 - t0, 161);
        check("b2b done spacing", t2 - t1, 161);

        // Random valid/data activity during the frame of 0x3C is ignored.
        fork
            send_frame(0, 8'h3C, DB0, SB0);
            begin
                @(posedge clk); #2;
                @(posedge clk); #2;
                for (int i = 0; i < 120; i++) begin
                    tx_valid_v[0] = 1'($urandom);
                    tx_data_v[0]  = 8'($urandom);
                    @(posedge clk); #2;
                end
                tx_valid_v[0] = 1'b0;
            end
        join

        // Reset in the middle of data bit 4 of 0xC3 abandons the frame.
        @(posedge clk); #1;
        tx_data_v[0] = 8'hC3; tx_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        tx_valid_v[0] = 1'b0;
        repeat (87) @(posedge clk);
        #1;
        check("pre-reset data bit 4", tx_out_v[0], 1'b0);
        rst_v[0] = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        check("mid-frame reset tx_out", tx_out_v[0], 1'b1);
        check("mid-frame reset busy", tx_busy_v[0], 1'b0);
        done_cnt = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (tx_done_v[0] === 1'b1) done_cnt++;
        end
        check("no done after abandoned frame", done_cnt, 0);
        send_frame(0, 8'h81, DB0, SB0);

        // 7 data bits, 2 stop bits: bit 7 of 0xD5 never reaches the line.
        send_frame(1, 8'hD5, DB1, SB1);

        // Random bytes with random gaps on both configurations.
        for (int n = 0; n < 5; n++) begin
            for (int g = 0; g < 2; g++) begin
                rnd = 8'($urandom);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send_frame(g, rnd, (g == 0) ? DB0 : DB1, (g == 0) ? SB0 : SB1);
            end
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
